// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
//   Shared types and helpers for the branch target buffer predictor.
//   - bp_state_t : init-sweep / run state of the predictor.
//   - BP_*_W     : default widths, used as the top-level parameter defaults.
//   - bp_entry_t : layout of one table entry {valid, tag, target, ctr} at the
//                  default widths.
//   - ctr_max / ctr_weak_t / ctr_next : saturating direction counter helpers.
//     They take the counter width as an argument, so one package serves any
//     CTR_W up to BP_CTR_MAX_W bits.
// ----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_t;

    localparam int BP_PC_W  = 20;
    localparam int BP_IDX_W = 10;
    localparam int BP_CTR_W = 2;
    localparam int BP_GHR_W = 8;

    // Widest counter the helper functions can handle.
    localparam int BP_CTR_MAX_W = 16;

    typedef logic [BP_CTR_MAX_W-1:0] ctr_word_t;

    typedef struct packed {
        logic                         valid;
        logic [BP_PC_W-BP_IDX_W-1:0]  tag;
        logic [BP_PC_W-1:0]           target;
        logic [BP_CTR_W-1:0]          ctr;
    } bp_entry_t;

    // Strongly-taken value: all ones.
    function automatic ctr_word_t ctr_max(input int w);
        return (ctr_word_t'(1) << w) - ctr_word_t'(1);
    endfunction

    // Weakly-taken value: only the MSB set.
    function automatic ctr_word_t ctr_weak_t(input int w);
        return ctr_word_t'(1) << (w - 1);
    endfunction

    // Saturating step toward taken (up=1) or not-taken (up=0); never wraps.
    function automatic ctr_word_t ctr_next(input ctr_word_t ctr, input logic up, input int w);
        ctr_word_t res;
        res = ctr;
        if (up) begin
            if (ctr != ctr_max(w)) res = ctr + ctr_word_t'(1);
        end else begin
            if (ctr != '0) res = ctr - ctr_word_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// ----------------------------------------------------------------------------
// bp_sat_ctr
//   Combinational saturating increment/decrement of a CTR_W-bit counter.
//   Ports:
//     ctr_i  in  CTR_W  current counter value
//     up_i   in  1      1 = step toward taken, 0 = step toward not-taken
//     ctr_o  out CTR_W  next counter value, clamped at 0 and 2**CTR_W-1
// ----------------------------------------------------------------------------
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_W = BP_CTR_W
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             up_i,
    output logic [CTR_W-1:0] ctr_o
);

    assign ctr_o = CTR_W'(ctr_next(ctr_word_t'(ctr_i), up_i, CTR_W));

endmodule

// File: rtl/bp_btb_predictor.sv
// ----------------------------------------------------------------------------
// bp_btb_predictor
//   Branch target buffer with per-entry saturating direction counters.
//   Fetch looks up lkp_pc_i combinationally; execute writes resolved branches
//   and jumps through the update port. After reset an init sweep clears one
//   valid bit per cycle; ready_o rises once all DEPTH entries are cleared.
//
//   Optional feature: define BP_GSHARE_EN to XOR a global history register
//   into the table index (gshare).
//
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     ready_o             init sweep finished, predictor live
//     lkp_pc_i            fetch PC
//     pred_hit_o          valid entry with matching tag
//     pred_taken_o        hit and counter MSB set
//     pred_target_o       stored target (0 on miss)
//     pred_ctr_o          stored counter (0 on miss)
//     upd_valid_i         resolved control-flow instruction this cycle
//     upd_pc_i            PC of resolved instruction
//     upd_is_jump_i       1 = unconditional jump, 0 = conditional branch
//     upd_taken_i         resolved direction (ignored for jumps)
//     upd_target_i        resolved target
// ----------------------------------------------------------------------------
module bp_btb_predictor
    import bp_pkg::*;
#(
    parameter int PC_W  = BP_PC_W,
    parameter int IDX_W = BP_IDX_W,
    parameter int CTR_W = BP_CTR_W,
    parameter int GHR_W = BP_GHR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready_o,
    input  logic [PC_W-1:0]   lkp_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [PC_W-1:0]   pred_target_o,
    output logic [CTR_W-1:0]  pred_ctr_o,
    input  logic              upd_valid_i,
    input  logic [PC_W-1:0]   upd_pc_i,
    input  logic              upd_is_jump_i,
    input  logic              upd_taken_i,
    input  logic [PC_W-1:0]   upd_target_i
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W;

    localparam logic [CTR_W-1:0] CTR_STRONG = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WEAK   = CTR_W'(ctr_weak_t(CTR_W));

    bp_state_t          state_q;
    logic [IDX_W-1:0]   sweep_q;
    logic               ready_q;

    logic [DEPTH-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_mem [DEPTH];
    logic [PC_W-1:0]    tgt_mem [DEPTH];
    logic [CTR_W-1:0]   ctr_mem [DEPTH];

    logic [IDX_W-1:0]   hash;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0]   ghr_q;
    // Zero-extended history folded into the low index bits.
    assign hash = IDX_W'(ghr_q);
`else
    assign hash = '0;
`endif

    // ------------------------------------------------------------------
    // Lookup: combinational, reads the table state before any write in
    // the same cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic             lkp_hit;

    assign lkp_idx = lkp_pc_i[IDX_W-1:0] ^ hash;
    assign lkp_tag = lkp_pc_i[PC_W-1:IDX_W];
    assign lkp_hit = ready_q && valid_q[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);

    assign ready_o       = ready_q;
    assign pred_hit_o    = lkp_hit;
    assign pred_taken_o  = lkp_hit && ctr_mem[lkp_idx][CTR_W-1];
    assign pred_target_o = lkp_hit ? tgt_mem[lkp_idx] : '0;
    assign pred_ctr_o    = lkp_hit ? ctr_mem[lkp_idx] : '0;

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_en;
    logic             upd_hit;
    logic [CTR_W-1:0] ctr_sat;
    logic             wr_en;
    logic [CTR_W-1:0] wr_ctr;

    assign upd_idx = upd_pc_i[IDX_W-1:0] ^ hash;
    assign upd_tag = upd_pc_i[PC_W-1:IDX_W];
    assign upd_en  = rst_n && (state_q == BP_RUN) && upd_valid_i;
    assign upd_hit = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    bp_sat_ctr #(
        .CTR_W (CTR_W)
    ) u_sat_ctr (
        .ctr_i (ctr_mem[upd_idx]),
        .up_i  (upd_taken_i),
        .ctr_o (ctr_sat)
    );

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_en  = 1'b0;
        wr_ctr = ctr_sat;
        if (upd_en) begin
            if (upd_is_jump_i) begin
                wr_en  = 1'b1;
                wr_ctr = CTR_STRONG;
            end else if (upd_hit) begin
                wr_en  = 1'b1;
            end else if (upd_taken_i) begin
                // Taken miss replaces whatever occupies the slot.
                wr_en  = 1'b1;
                wr_ctr = CTR_WEAK;
            end
        end
    end

    // ------------------------------------------------------------------
    // Init sweep / run control
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BP_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                BP_INIT: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= BP_RUN;
                        ready_q <= 1'b1;
                    end
                end
                BP_RUN: begin
                    state_q <= BP_RUN;
                end
                default: begin
                    state_q <= BP_INIT;
                end
            endcase
        end
    end

    // NOTE: the valid bits are not cleared by reset directly; the init sweep
    // clears them one per cycle, which keeps the array a plain memory.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == BP_INIT) begin
                valid_q[sweep_q] <= 1'b0;
            end else if (wr_en) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // Payload fields carry no reset; they are only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[upd_idx] <= upd_tag;
            tgt_mem[upd_idx] <= upd_target_i;
            ctr_mem[upd_idx] <= wr_ctr;
        end
    end

`ifdef BP_GSHARE_EN
    // History shifts on conditional branches only; the table write in the
    // same cycle already used the pre-shift value through hash.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (upd_en && !upd_is_jump_i) begin
            ghr_q <= {ghr_q[GHR_W-2:0], upd_taken_i};
        end
    end
`endif

endmodule
